seq_ula_controle: RTL and testbench
===================================

SEQ_ULA_CONTROLE -- requirements
Module: seq_ula_controle

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all other signals are synchronous to the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 start  in  1  operation request; sampled only in IDLE.
REQ-005 op_sel  in  2  operation: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-006 base_addr  in  9  ROM address of operand A; operand B is at base_addr+1 (mod 512).
REQ-007 rom_addr  out  9  address to the synchronous ROM (data valid one cycle after address).
REQ-008 rom_data  in  8  ROM read data.
REQ-009 alu_a, alu_b  out  16 each  ALU operands.
REQ-010 alu_op  out  1  0 = add, 1 = subtract.
REQ-011 alu_y  in  16  combinational ALU result, (alu_a ± alu_b) mod 2^16.
REQ-012 result  out  16  sum/difference/product/quotient.
REQ-013 remainder  out  16  division remainder; 0 for other ops.
REQ-014 iter_count  out  8  loop iterations executed in the current/last operation.
REQ-015 busy  out  1  high from the cycle after start is accepted until DONE inclusive.
REQ-016 done  out  1  one-cycle pulse in DONE.
REQ-017 div_zero  out  1  set when divide with B = 0; held until next accepted start.

Function
REQ-018 States: IDLE, LOAD_A, LOAD_B, CAPT_B, EXEC, DONE; encoding is free.
REQ-019 IDLE: start=1 latches op_sel and base_addr, clears result, remainder, iter_count, div_zero; next LOAD_A.
REQ-020 LOAD_A: rom_addr = base; next LOAD_B.
REQ-021 LOAD_B: rom_addr = base+1 mod 512; A = zero-extended rom_data captured; next CAPT_B.
REQ-022 CAPT_B: B = zero-extended rom_data captured; accumulator initialised (add/sub/mul: 0; div: A); next EXEC.
REQ-023 EXEC add/sub: alu_a=A, alu_b=B, alu_op per op; result <= alu_y; exactly one cycle; subtract wraps mod 2^16.
REQ-024 EXEC multiply: per cycle alu_a=acc, alu_b=A, alu_op=0, acc <= alu_y, iter_count++ while iter_count < B; exits when iter_count == B; B=0 spends one cycle, result 0.
REQ-025 EXEC divide: per cycle, if acc >= B: alu_a=acc, alu_b=B, alu_op=1, acc <= alu_y, iter_count++; else result <= iter_count, remainder <= acc, exit; cycles = quotient+1.
REQ-026 Divide with B=0: one EXEC cycle, div_zero=1, result=16'hFFFF, remainder=A, iter_count=0.
REQ-027 Multiply result (max 255*255=65025) and quotient (max 255) SHALL never overflow 16 bits.
REQ-028 DONE: done=1 for one cycle, next IDLE; result, remainder, iter_count, div_zero hold until the next accepted start.
REQ-029 start while busy SHALL be ignored, not queued; start held high in DONE is not accepted until IDLE.
REQ-030 Latency start-sample edge to done: add/sub 4 cycles; multiply 3+max(B,1); divide 3+quotient+1.
REQ-031 alu_a, alu_b, alu_op, rom_addr SHALL be 0 outside the states that use them.

Reset
REQ-032 reset=1 at any time SHALL force IDLE immediately and clear all outputs and internal registers to 0, aborting any operation without a done pulse.
REQ-033 After reset release the first rising edge with start=1 SHALL be accepted.

Verification
REQ-034 ROM[10]=7, ROM[11]=5, op=00, base=10 -> done 4 cycles after start, result=12, remainder=0.
REQ-035 ROM[10]=5, ROM[11]=7, op=01 -> result=16'hFFFE.
REQ-036 ROM[20]=255, ROM[21]=255, op=10 -> result=65025, iter_count=255, done 258 cycles after start; repeat with B=0 -> result=0, done after 4 cycles.
REQ-037 ROM[30]=100, ROM[31]=7, op=11 -> result=14, remainder=2, done 18 cycles after start; B=0 -> div_zero=1, result=16'hFFFF, remainder=100.
REQ-038 base=511 -> B read from address 0; start pulsed during EXEC ignored; reset asserted mid-multiply -> all outputs 0, no done, next start runs normally.

Source files
------------

// File: rtl/seq_ula_controle_if.sv
// Controller <-> host/ROM/ALU signal bundle.
// master drives requests and returns ROM/ALU data; slave is the controller.
interface seq_ula_controle_if;
  logic        start;
  logic [1:0]  op_sel;
  logic [8:0]  base_addr;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_op;
  logic [15:0] alu_y;
  logic [15:0] result;
  logic [15:0] remainder;
  logic [7:0]  iter_count;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op_sel, base_addr, rom_data, alu_y,
    input  rom_addr, alu_a, alu_b, alu_op, result, remainder, iter_count, busy, done, div_zero
  );

  modport slave (
    input  start, op_sel, base_addr, rom_data, alu_y,
    output rom_addr, alu_a, alu_b, alu_op, result, remainder, iter_count, busy, done, div_zero
  );
endinterface

// File: rtl/seq_ula_controle.sv
// Sequential arithmetic controller: fetches two ROM bytes, then add/sub/mul/div via an external add/sub ALU.
// Latency start->done: add/sub 4, mul 3+max(B,1), div 4+quotient; start ignored while busy.
module seq_ula_controle (
  input  logic               clk,
  input  logic               reset,
  seq_ula_controle_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CAPT_B, EXEC, DONE} state_t;

  state_t      state;
  logic [1:0]  op;
  logic [8:0]  base;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [15:0] acc;

  logic [15:0] a_ext;
  logic [15:0] b_ext;
  logic [15:0] rom_ext;
  logic [8:0]  iter_next;
  logic        last_mul;
  logic        y_ge_b;

  assign a_ext     = {8'd0, a_reg};
  assign b_ext     = {8'd0, b_reg};
  assign rom_ext   = {8'd0, bus.rom_data};
  assign iter_next = {1'b0, bus.iter_count} + 9'd1;
  assign last_mul  = (iter_next == {1'b0, b_reg});
  assign y_ge_b    = (bus.alu_y >= b_ext);

  // ALU operands are registered one cycle ahead, so each EXEC step also prepares the next step's operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      op             <= 2'd0;
      base           <= 9'd0;
      a_reg          <= 8'd0;
      b_reg          <= 8'd0;
      acc            <= 16'd0;
      bus.rom_addr   <= 9'd0;
      bus.alu_a      <= 16'd0;
      bus.alu_b      <= 16'd0;
      bus.alu_op     <= 1'b0;
      bus.result     <= 16'd0;
      bus.remainder  <= 16'd0;
      bus.iter_count <= 8'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.div_zero   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op             <= bus.op_sel;
            base           <= bus.base_addr;
            bus.result     <= 16'd0;
            bus.remainder  <= 16'd0;
            bus.iter_count <= 8'd0;
            bus.div_zero   <= 1'b0;
            bus.busy       <= 1'b1;
            bus.rom_addr   <= bus.base_addr;
            state          <= LOAD_A;
          end
        end
        LOAD_A: begin
          bus.rom_addr <= base + 9'd1;
          state        <= LOAD_B;
        end
        LOAD_B: begin
          a_reg        <= bus.rom_data;
          bus.rom_addr <= 9'd0;
          state        <= CAPT_B;
        end
        CAPT_B: begin
          b_reg <= bus.rom_data;
          state <= EXEC;
          case (op)
            2'b00, 2'b01: begin
              acc        <= 16'd0;
              bus.alu_a  <= a_ext;
              bus.alu_b  <= rom_ext;
              bus.alu_op <= op[0];
            end
            2'b10: begin
              acc <= 16'd0;
              if (bus.rom_data != 8'd0) begin
                bus.alu_a  <= 16'd0;
                bus.alu_b  <= a_ext;
                bus.alu_op <= 1'b0;
              end
            end
            default: begin
              acc <= a_ext;
              if (bus.rom_data != 8'd0 && a_reg >= bus.rom_data) begin
                bus.alu_a  <= a_ext;
                bus.alu_b  <= rom_ext;
                bus.alu_op <= 1'b1;
              end
            end
          endcase
        end
        EXEC: begin
          case (op)
            2'b00, 2'b01: begin
              bus.result <= bus.alu_y;
              bus.alu_a  <= 16'd0;
              bus.alu_b  <= 16'd0;
              bus.alu_op <= 1'b0;
              bus.done   <= 1'b1;
              state      <= DONE;
            end
            2'b10: begin
              if (b_reg == 8'd0) begin
                bus.done <= 1'b1;
                state    <= DONE;
              end else begin
                acc            <= bus.alu_y;
                bus.iter_count <= iter_next[7:0];
                bus.alu_a      <= bus.alu_y;
                if (last_mul) begin
                  bus.result <= bus.alu_y;
                  bus.alu_a  <= 16'd0;
                  bus.alu_b  <= 16'd0;
                  bus.done   <= 1'b1;
                  state      <= DONE;
                end
              end
            end
            default: begin
              if (b_reg == 8'd0) begin
                bus.div_zero  <= 1'b1;
                bus.result    <= 16'hFFFF;
                bus.remainder <= a_ext;
                bus.done      <= 1'b1;
                state         <= DONE;
              end else if (acc >= b_ext) begin
                acc            <= bus.alu_y;
                bus.iter_count <= iter_next[7:0];
                if (y_ge_b) begin
                  bus.alu_a <= bus.alu_y;
                end else begin
                  bus.alu_a  <= 16'd0;
                  bus.alu_b  <= 16'd0;
                  bus.alu_op <= 1'b0;
                end
              end else begin
                bus.result    <= {8'd0, bus.iter_count};
                bus.remainder <= acc;
                bus.done      <= 1'b1;
                state         <= DONE;
              end
            end
          endcase
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ula_controle.sv
// Bench for seq_ula_controle: behavioural ROM/ALU, arithmetic reference model, per-cycle compare.
module tb_seq_ula_controle;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_ula_controle_if bus ();
  seq_ula_controle dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] rom [0:511];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  assign bus.alu_y = bus.alu_op ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

  int n_pass = 0;
  int n_total = 0;

  // Reference expectations for the operation in flight.
  bit m_active = 1'b0;
  int m_cnt, m_lat, m_op, m_base, m_a, m_b;
  int e_res, e_rem, e_it, e_dz;
  int done_at;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // m_cnt = 0 is the first cycle after the accepting edge; DONE is m_cnt == m_lat.
  always @(negedge clk) begin
    if (m_active) begin
      m_cnt++;
      if (bus.done && done_at < 0) done_at = m_cnt;
      chk("busy", bus.busy, 64'(m_cnt <= m_lat));
      chk("done", bus.done, 64'(m_cnt == m_lat));
      chk("rom_addr", bus.rom_addr,
          (m_cnt == 0) ? 64'(m_base) : (m_cnt == 1) ? 64'((m_base + 1) % 512) : 64'd0);
      if (m_cnt <= 2 || m_cnt >= m_lat)
        chk("alu_quiet", {bus.alu_a, bus.alu_b, bus.alu_op}, 64'd0);
      if (m_cnt == 3) begin
        if (m_op < 2)
          chk("alu_addsub", {bus.alu_a, bus.alu_b, bus.alu_op}, {16'(m_a), 16'(m_b), 1'(m_op)});
        else if (m_op == 2 && m_b > 0)
          chk("alu_mul0", {bus.alu_a, bus.alu_b, bus.alu_op}, {16'd0, 16'(m_a), 1'b0});
        else if (m_op == 3 && m_b > 0 && m_a >= m_b)
          chk("alu_div0", {bus.alu_a, bus.alu_b, bus.alu_op}, {16'(m_a), 16'(m_b), 1'b1});
      end
      if (m_cnt >= m_lat) begin
        chk("result", bus.result, 64'(e_res));
        chk("remainder", bus.remainder, 64'(e_rem));
        chk("iter_count", bus.iter_count, 64'(e_it));
        chk("div_zero", bus.div_zero, 64'(e_dz));
      end else begin
        chk("cleared", {bus.result, bus.remainder, bus.div_zero}, 64'd0);
      end
    end else if (!reset) begin
      chk("idle", {bus.busy, bus.done, bus.rom_addr, bus.alu_a, bus.alu_b, bus.alu_op}, 64'd0);
    end
  end

  task automatic check_all_zero(input string name);
    chk(name, {bus.result, bus.remainder, bus.iter_count, bus.busy, bus.done, bus.div_zero}, 64'd0);
    chk({name, "_bus"}, {bus.rom_addr, bus.alu_a, bus.alu_b, bus.alu_op}, 64'd0);
  endtask

  task automatic run_op(input int op, input int base, input int a, input int b,
                        input int glitch, input int abort);
    logic [8:0] b_addr;
    b_addr = 9'(base) + 9'd1;
    rom[9'(base)] = 8'(a);
    rom[b_addr]   = 8'(b);
    m_op = op; m_base = base; m_a = a; m_b = b;
    e_rem = 0; e_it = 0; e_dz = 0;
    case (op)
      0: begin e_res = (a + b) % 65536; m_lat = 4; end
      1: begin e_res = (a - b + 65536) % 65536; m_lat = 4; end
      2: begin e_res = a * b; e_it = b; m_lat = 3 + ((b > 0) ? b : 1); end
      default: begin
        if (b == 0) begin e_res = 65535; e_rem = a; e_dz = 1; m_lat = 4; end
        else begin e_res = a / b; e_rem = a % b; e_it = a / b; m_lat = 4 + a / b; end
      end
    endcase
    @(negedge clk); #1;
    bus.start = 1'b1; bus.op_sel = 2'(op); bus.base_addr = 9'(base);
    m_cnt = -1; done_at = -1; m_active = 1'b1;
    for (int k = 0; k <= m_lat + 1; k++) begin
      @(negedge clk); #1;
      // Scramble request fields mid-operation: the latched copies must be used.
      bus.op_sel    = 2'($urandom_range(3));
      bus.base_addr = 9'($urandom_range(511));
      bus.start     = (k == glitch);
      if (k == abort) begin
        reset = 1'b1; m_active = 1'b0; bus.start = 1'b0;
        #1 check_all_zero("abort_zero");
        repeat (2) @(negedge clk);
        #1 check_all_zero("abort_held");
        reset = 1'b0;
        return;
      end
    end
    m_active = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op_sel = 2'd0; bus.base_addr = 9'd0;
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom_range(255));
    @(posedge clk); #1;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    run_op(0, 10, 7, 5, -1, -1);
    chk("lit_add_result", bus.result, 64'd12);
    chk("lit_add_lat", done_at, 64'd4);
    run_op(1, 10, 5, 7, -1, -1);
    chk("lit_sub_result", bus.result, 64'hFFFE);
    run_op(2, 20, 255, 255, -1, -1);
    chk("lit_mul_result", bus.result, 64'd65025);
    chk("lit_mul_iter", bus.iter_count, 64'd255);
    chk("lit_mul_lat", done_at, 64'd258);
    run_op(2, 20, 255, 0, -1, -1);
    chk("lit_mul0_result", bus.result, 64'd0);
    chk("lit_mul0_lat", done_at, 64'd4);
    run_op(3, 30, 100, 7, -1, -1);
    chk("lit_div_q", bus.result, 64'd14);
    chk("lit_div_r", bus.remainder, 64'd2);
    chk("lit_div_lat", done_at, 64'd18);
    run_op(3, 30, 100, 0, -1, -1);
    chk("lit_div0_flag", bus.div_zero, 64'd1);
    chk("lit_div0_result", bus.result, 64'hFFFF);
    chk("lit_div0_rem", bus.remainder, 64'd100);
    run_op(0, 511, 9, 3, -1, -1);
    chk("lit_wrap_result", bus.result, 64'd12);
    run_op(2, 40, 10, 20, 10, -1);        // start pulsed in EXEC
    chk("lit_glitch_result", bus.result, 64'd200);
    run_op(3, 50, 200, 9, 0, -1);         // start pulsed while LOAD_A: ignored
    run_op(1, 60, 3, 3, 4, -1);           // start pulsed in DONE
    run_op(2, 70, 200, 200, -1, 100);     // reset mid-multiply
    chk("post_reset_no_done", done_at, 64'(-1));
    run_op(0, 80, 200, 100, -1, -1);
    chk("lit_after_reset", bus.result, 64'd300);

    for (int n = 0; n < 40; n++) begin
      int op, a, b, g;
      op = $urandom_range(3);
      a  = $urandom_range(255);
      b  = ($urandom_range(7) == 0) ? 0 : $urandom_range(255);
      if (op == 2 && $urandom_range(1) == 1) b = $urandom_range(15);
      run_op(op, $urandom_range(511), a, b, -1, -1);
      g = ($urandom_range(1) == 1) ? $urandom_range(m_lat, 3) : -1;
      if (g >= 0) run_op(op ^ 1, $urandom_range(511), b, a, g, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
